// File: rtl/qtest_s2_packer_pkg.sv
// Shared definitions for the s2 byte packer.
//   LANES   : bytes per 64-bit RAM word (fixed at 8)
//   LANE_W  : width of a lane index
//   state_e : packer FSM states
package qtest_s2_packer_pkg;
    localparam int LANES  = 8;
    localparam int LANE_W = $clog2(LANES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_PACK  = 2'd2
    } state_e;
endpackage

// File: rtl/qtest_s2_lane_packer.sv
// Assembles bytes little-endian into one 64-bit word.
//   clk, reset_n : clock, async active-low reset
//   clear_i      : drop any partial word
//   load_i       : insert data_i into the current lane
//   flush_i      : with load_i, the word is complete; restart at lane 0
//   data_i       : byte to insert
//   full_o       : current lane is the last one
//   word_o/be_o  : word and byte enables including a byte being loaded now
module qtest_s2_lane_packer
    import qtest_s2_packer_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear_i,
    input  logic                 load_i,
    input  logic                 flush_i,
    input  logic [7:0]           data_i,
    output logic                 full_o,
    output logic [8*LANES-1:0]   word_o,
    output logic [LANES-1:0]     be_o
);
    logic [LANE_W-1:0]  lane_q;
    logic [8*LANES-1:0] word_q;
    logic [LANES-1:0]   be_q;
    logic [5:0]         bit_idx;

    assign bit_idx = {lane_q, 3'b000};
    assign full_o  = (lane_q == LANE_W'(LANES - 1));

    // Present the word as it will look after this load so the top can
    // register the completed word on the same edge the last byte lands.
    always_comb begin
        word_o = word_q;
        be_o   = be_q;
        if (load_i) begin
            word_o[bit_idx +: 8] = data_i;
            be_o[lane_q]         = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lane_q <= '0;
            word_q <= '0;
            be_q   <= '0;
        end else if (clear_i || (load_i && flush_i)) begin
            lane_q <= '0;
            word_q <= '0;
            be_q   <= '0;
        end else if (load_i) begin
            lane_q <= lane_q + 1'b1;
            word_q <= word_o;
            be_q   <= be_o;
        end
    end
endmodule

// File: rtl/qtest_s2_byte_packer.sv
// Byte-stream to 64-bit word packer feeding the RAM's s2 write port.
//   clk, reset_n            : clock, async active-low reset
//   start, start_addr       : arm the packer at a word address (when not busy)
//   in_data/valid/sop/eop   : byte stream in; in_ready = accepting
//   mem_*                   : registered single-cycle byte-enabled writes
//   busy, done              : activity / final-write pulse
//   words_written           : writes issued for the current packet
//   wrapped, proto_err      : sticky address-wrap and mid-packet-sop flags
module qtest_s2_byte_packer
    import qtest_s2_packer_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_sop,
    input  logic              in_eop,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [7:0]        mem_byteenable,
    output logic [63:0]       mem_writedata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_written,
    output logic              wrapped,
    output logic              proto_err
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, mem_addr_q;
    logic [ADDR_W:0]   words_q;
    logic              wrapped_q, perr_q, mem_write_q, done_q;
    logic [7:0]        be_q;
    logic [63:0]       data_q;

    logic        accept, start_acc, load, complete, perr_set, lane_full;
    logic [63:0] word_nxt;
    logic [7:0]  be_nxt;

    assign in_ready  = (state_q != ST_IDLE);
    assign busy      = (state_q != ST_IDLE) || mem_write_q;
    assign accept    = in_valid && in_ready;
    assign start_acc = start && !busy;

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        complete = 1'b0;
        perr_set = 1'b0;
        case (state_q)
            ST_IDLE: if (start_acc) state_d = ST_ARMED;
            ST_ARMED: begin
                // Bytes before the sop are discarded silently.
                if (accept && in_sop) begin
                    load     = 1'b1;
                    complete = in_eop;
                    state_d  = in_eop ? ST_IDLE : ST_PACK;
                end
            end
            ST_PACK: begin
                if (accept) begin
                    load     = 1'b1;
                    perr_set = in_sop;
                    complete = in_eop || lane_full;
                    if (in_eop) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    qtest_s2_lane_packer u_lanes (
        .clk     (clk),
        .reset_n (reset_n),
        .clear_i (start_acc),
        .load_i  (load),
        .flush_i (complete),
        .data_i  (in_data),
        .full_o  (lane_full),
        .word_o  (word_nxt),
        .be_o    (be_nxt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            words_q     <= '0;
            wrapped_q   <= 1'b0;
            perr_q      <= 1'b0;
            mem_write_q <= 1'b0;
            done_q      <= 1'b0;
            mem_addr_q  <= '0;
            be_q        <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            mem_write_q <= complete;
            done_q      <= complete && in_eop;
            if (start_acc) begin
                addr_q    <= start_addr;
                words_q   <= '0;
                wrapped_q <= 1'b0;
                perr_q    <= 1'b0;
            end
            if (perr_set) perr_q <= 1'b1;
            if (complete) begin
                mem_addr_q <= addr_q;
                data_q     <= word_nxt;
                be_q       <= be_nxt;
                addr_q     <= addr_q + 1'b1;   // natural wrap to 0
                words_q    <= words_q + 1'b1;
                if (&addr_q) wrapped_q <= 1'b1;
            end
        end
    end

    assign mem_address    = mem_addr_q;
    assign mem_chipselect = mem_write_q;
    assign mem_write      = mem_write_q;
    assign mem_byteenable = be_q;
    assign mem_writedata  = data_q;
    assign done           = done_q;
    assign words_written  = words_q;
    assign wrapped        = wrapped_q;
    assign proto_err      = perr_q;
endmodule
